vc_output_scheduler: RTL



---
 rtl/vc_output_scheduler_pkg.sv | 24 ++
 rtl/vc_output_scheduler_if.sv | 38 +++
 rtl/vc_output_scheduler_arbiter.sv | 49 ++++
 rtl/vc_output_scheduler.sv | 113 +++++++++++
 4 files changed

// File: rtl/vc_output_scheduler_pkg.sv
// Shared types and helpers for the VC output scheduler slice.
// Contents:
//   flit_t       - default flit payload type carried through the scheduler
//   fifo_flags_t - per-VC status flags reported by the VC buffer bank
//   clog2()      - ceiling log2 with a minimum result of 1, for sizing fields
package vc_output_scheduler_pkg;

  typedef logic [15:0] flit_t;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/vc_output_scheduler_if.sv
// Bundle of signals between the VC buffer bank / downstream link and the
// output scheduler.
// Modports:
//   master - scheduler side: consumes flags, buf_data, credit_in; drives
//            select, pop, flit_out, flit_valid, vc_out, credit_cnt
//   slave  - bank/link side: the mirror image of master
interface vc_output_scheduler_if
  import vc_output_scheduler_pkg::*;
#(
  parameter int  n         = 4,
  parameter int  buf_depth = 3,
  parameter type flit_t    = vc_output_scheduler_pkg::flit_t
);

  localparam int vw = clog2(n);
  localparam int cw = clog2(buf_depth + 1);

  fifo_flags_t [n-1:0]         flags;
  flit_t                       buf_data;
  logic        [n-1:0]         select;
  logic        [n-1:0]         pop;
  logic        [n-1:0]         credit_in;
  flit_t                       flit_out;
  logic                        flit_valid;
  logic        [vw-1:0]        vc_out;
  logic        [n-1:0][cw-1:0] credit_cnt;

  modport master (
    input  flags, buf_data, credit_in,
    output select, pop, flit_out, flit_valid, vc_out, credit_cnt
  );

  modport slave (
    output flags, buf_data, credit_in,
    input  select, pop, flit_out, flit_valid, vc_out, credit_cnt
  );

endinterface

// File: rtl/vc_output_scheduler_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst - clock and synchronous active-high reset (pointer -> entry 0)
//   request  - request vector
//   advance  - when high and a grant is issued, the pointer moves past it
//   grant    - one-hot (or zero) grant, combinational from request/pointer
//   pointer  - one-hot current priority pointer
module vc_rr_arbiter
  import vc_output_scheduler_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] request,
  input  logic         advance,
  output logic [n-1:0] grant,
  output logic [n-1:0] pointer
);

  localparam int vw = clog2(n);

  logic [vw-1:0] ptr_q;
  logic [vw-1:0] ptr_d;

  // Scan from the pointer upwards (wrapping); the first requester wins and
  // the candidate next pointer is the entry just after it.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < n; k++) begin
      if (grant == '0 && request[(int'(ptr_q) + k) % n]) begin
        grant[(int'(ptr_q) + k) % n] = 1'b1;
        ptr_d = vw'(((int'(ptr_q) + k) % n + 1) % n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && (grant != '0)) begin
      ptr_q <= ptr_d;
    end
  end

  assign pointer = {{(n-1){1'b0}}, 1'b1} << ptr_q;

endmodule

// File: rtl/vc_output_scheduler.sv
// Output scheduler downstream of a per-port VC buffer bank. Picks one
// non-empty VC with downstream credit per cycle (round-robin), pops it from
// the bank and registers its head flit onto the output link with the VC id.
// One credit counter per VC mirrors free slots in the next router.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   bus      - master side of vc_output_scheduler_if (flags, buf_data,
//              credit_in in; select, pop, flit_out, flit_valid, vc_out,
//              credit_cnt out)
module vc_output_scheduler
  import vc_output_scheduler_pkg::*;
#(
  parameter int  n         = 4,
  parameter int  buf_depth = 3,
  parameter type flit_t    = vc_output_scheduler_pkg::flit_t
) (
  input  logic                  clk,
  input  logic                  rst,
  vc_output_scheduler_if.master bus
);

  localparam int vw = clog2(n);
  localparam int cw = clog2(buf_depth + 1);
  localparam logic [cw-1:0] full_credit = cw'(buf_depth);

  logic [n-1:0]         eligible;
  logic [n-1:0]         grant;
  logic [n-1:0]         pointer;
  logic [vw-1:0]        grant_idx;
  logic [n-1:0][cw-1:0] credit;
  logic                 flags_unused;

  // Masking with rst keeps the bank untouched during a reset cycle.
  always_comb begin
    eligible     = '0;
    flags_unused = 1'b0;
    for (int i = 0; i < n; i++) begin
      eligible[i]  = !rst && !bus.flags[i].empty && (credit[i] != '0);
      flags_unused = flags_unused ^ bus.flags[i].full;
    end
  end

  vc_rr_arbiter #(.n(n)) u_arbiter (
    .clk     (clk),
    .rst     (rst),
    .request (eligible),
    .advance (grant != '0),
    .grant   (grant),
    .pointer (pointer)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < n; i++) begin
      if (grant[i]) grant_idx = vw'(i);
    end
  end

  // With nothing eligible the bank still sees a valid one-hot select so its
  // data_out is always a defined head.
  assign bus.select = (grant != '0) ? grant : pointer;
  assign bus.pop    = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.flit_valid <= 1'b0;
      bus.vc_out     <= '0;
    end else if (grant != '0) begin
      bus.flit_valid <= 1'b1;
      bus.flit_out   <= bus.buf_data;
      bus.vc_out     <= grant_idx;
    end else begin
      bus.flit_valid <= 1'b0;
    end
  end

  // A grant consumes a downstream slot, a credit pulse frees one; both in
  // the same cycle cancel out.
  for (genvar i = 0; i < n; i++) begin : g_credit
    always_ff @(posedge clk) begin
      if (rst) begin
        credit[i] <= full_credit;
      end else if (grant[i] && !bus.credit_in[i]) begin
        credit[i] <= credit[i] - 1'b1;
      end else if (bus.credit_in[i] && !grant[i]) begin
        credit[i] <= credit[i] + 1'b1;
      end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(bus.credit_in[i] && (credit[i] == full_credit)))
      else $fatal(1, "credit returned to a VC already holding full credit");

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(bus.pop[i] && bus.flags[i].empty))
      else $fatal(1, "pop issued to an empty VC");
  end

  assign bus.credit_cnt = credit;

  a_pop_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.pop))
    else $fatal(1, "pop is not onehot0");

  a_select_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(bus.select))
    else $fatal(1, "select is not onehot");

  a_credit_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.credit_in))
    else $fatal(1, "credit_in is unknown");

endmodule
